// File: rtl/rf_fill.sv
// rf_fill: register-cache fill engine on the shared register-file bus.
// Finds entries flagged for retrieval, issues one 16-bit memory read per entry
// and writes the returned value back into that entry, clearing its retr bit.
// Optional build macro: RF_FILL_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT cycles.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | arbitrating round-robin for the next candidate entry
// S_REQ  | read request held on the bus until granted
// S_WAIT | read accepted, waiting for the data strobe
// S_DONE | one cycle: write data into the entry if it is still the same fill
module rf_fill #(
  parameter int NCORES  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCORES*35-1:0]   rf_in,
  output logic [NCORES*35-1:0]   rf_out,
  output logic                   mem_rd_req,
  output logic [15:0]            mem_rd_addr,
  input  logic                   mem_rd_gnt,
  input  logic                   mem_rd_valid,
  input  logic [15:0]            mem_rd_data,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic                   fill_timeout
);

  localparam int EW   = 35;
  localparam int IDXW = (NCORES > 1) ? $clog2(NCORES) : 1;

  if (NCORES < 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("rf_fill: NCORES must be >= 1 and TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW-1:0]   rr_last_q;
  logic [15:0]       tag_q;
  logic [15:0]       data_q;
  logic              req_q;
  logic [15:0]       addr_q;
  logic              busy_q;

  logic [NCORES-1:0] cand;
  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic [15:0]       pick_tag;
  logic [EW-1:0]     cur_ent;
  logic              hit;

`ifdef RF_FILL_TIMEOUT_EN
  logic [15:0]       wcnt_q;
  logic              timeout_q;
`endif

  // Candidate flags: entry valid and marked for retrieval.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NCORES; i++) begin
      cand[i] = rf_in[i*EW + 34] & rf_in[i*EW + 33];
    end
  end

  // Round-robin pick: first candidate after rr_last_q, wrapping.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NCORES; k++) begin
      j = (int'(rr_last_q) + k) % NCORES;
      if (!pick_found && cand[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(j);
      end
    end
    pick_tag = rf_in[int'(pick_idx)*EW + 16 +: 16];
  end

  // Re-check the entry being filled against the live bus so writeback wins.
  always_comb begin
    cur_ent = rf_in[int'(idx_q)*EW +: EW];
    hit     = cur_ent[34] & cur_ent[33] & (cur_ent[31:16] == tag_q);
  end

  // Pass-through bus with at most one entry replaced in DONE.
  always_comb begin
    rf_out    = rf_in;
    fill_done = 1'b0;
    if (state_q == S_DONE && hit) begin
      fill_done = 1'b1;
      rf_out[int'(idx_q)*EW +: EW] = {1'b1, 1'b0, cur_ent[32], tag_q, data_q};
    end
  end

  // Fill sequencer with registered bus-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rr_last_q <= IDXW'(NCORES - 1);
      tag_q     <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
`ifdef RF_FILL_TIMEOUT_EN
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RF_FILL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            idx_q   <= pick_idx;
            tag_q   <= pick_tag;
            addr_q  <= pick_tag;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_rd_gnt) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
`ifdef RF_FILL_TIMEOUT_EN
            wcnt_q  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (mem_rd_valid) begin
            data_q  <= mem_rd_data;
            state_q <= S_DONE;
          end
`ifdef RF_FILL_TIMEOUT_EN
          else if (wcnt_q + 16'd1 == 16'(TIMEOUT)) begin
            // Abort; the entry keeps retr set and is arbitrated again later.
            rr_last_q <= idx_q;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            wcnt_q <= wcnt_q + 16'd1;
          end
`endif
        end
        S_DONE: begin
          rr_last_q <= idx_q;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_req  = req_q;
  assign mem_rd_addr = addr_q;
  assign fill_busy   = busy_q;
`ifdef RF_FILL_TIMEOUT_EN
  assign fill_timeout = timeout_q;
`else
  assign fill_timeout = 1'b0;
`endif

endmodule
